// File: rtl/booth_mult_param.sv
// Sequential radix-2 Booth multiplier, WIDTH x WIDTH -> {hi,lo}, signed or unsigned.
// One Booth step per clock; start is ignored while busy.
module booth_mult_param #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mult_ctrl,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             mult_end
);

   localparam int unsigned E     = WIDTH + 1;
   localparam int unsigned PW    = 2 * E + 1;
   localparam int unsigned CNT_W = $clog2(WIDTH + 2);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [PW-1:0]      r_p;
   logic [PW-1:0]      w_p_nxt;
   logic [E-1:0]       r_m;
   logic [E-1:0]       w_m_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_signed;
   logic               w_signed_nxt;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   w_hi_nxt;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   w_lo_nxt;
   logic               r_busy;
   logic               w_busy_nxt;
   logic               r_end;
   logic               w_end_nxt;

   logic [E-1:0]       w_a_ext;
   logic [E-1:0]       w_b_ext;
   logic [E-1:0]       w_upper;
   logic [E-1:0]       w_sum;
   logic [PW-1:0]      w_shifted;
   logic [2*WIDTH-1:0] w_result;

   // Operand extension and one Booth add/subtract + arithmetic shift
   always_comb begin
      w_a_ext = {is_signed & a[WIDTH-1], a};
      w_b_ext = {is_signed & b[WIDTH-1], b};
      w_upper = r_p[PW-1 -: E];
      case (r_p[1:0])
         2'b01:   w_sum = w_upper + r_m;
         2'b10:   w_sum = w_upper - r_m;
         default: w_sum = w_upper;
      endcase
      w_shifted = {w_sum[E-1], w_sum, r_p[E:1]};
   end

   // Signed mode skips the final step, which would only be a sign-replicating
   // shift, so its product window sits one bit higher.
   always_comb begin
      if (r_signed) w_result = w_shifted[2*WIDTH+1:2];
      else          w_result = w_shifted[2*WIDTH:1];
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_p_nxt      = r_p;
      w_m_nxt      = r_m;
      w_cnt_nxt    = r_cnt;
      w_signed_nxt = r_signed;
      w_hi_nxt     = r_hi;
      w_lo_nxt     = r_lo;
      w_busy_nxt   = r_busy;
      w_end_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mult_ctrl) begin
               w_m_nxt      = w_a_ext;
               w_p_nxt      = {{E{1'b0}}, w_b_ext, 1'b0};
               w_cnt_nxt    = is_signed ? CNT_W'(WIDTH) : CNT_W'(E);
               w_signed_nxt = is_signed;
               w_busy_nxt   = 1'b1;
               w_state_nxt  = S_RUN;
            end
         end
         S_RUN: begin
            w_p_nxt   = w_shifted;
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_hi_nxt    = w_result[2*WIDTH-1:WIDTH];
               w_lo_nxt    = w_result[WIDTH-1:0];
               w_end_nxt   = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_p      <= '0;
         r_m      <= '0;
         r_cnt    <= '0;
         r_signed <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_end    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_p      <= w_p_nxt;
         r_m      <= w_m_nxt;
         r_cnt    <= w_cnt_nxt;
         r_signed <= w_signed_nxt;
         r_hi     <= w_hi_nxt;
         r_lo     <= w_lo_nxt;
         r_busy   <= w_busy_nxt;
         r_end    <= w_end_nxt;
      end
   end

   assign hi       = r_hi;
   assign lo       = r_lo;
   assign busy     = r_busy;
   assign mult_end = r_end;

endmodule

// File: tb/tb_booth_mult_param.sv
// Bench for booth_mult_param: 32-, 13- and 8-bit instances share one stimulus
// and are checked against a plain-arithmetic product model.
module tb_booth_mult_param;

   logic        clk = 1'b0;
   logic        reset;
   logic        mult_ctrl;
   logic        is_signed;
   logic [63:0] a;
   logic [63:0] b;

   logic [31:0] hi32, lo32;
   logic        busy32, end32;
   logic [12:0] hi13, lo13;
   logic        busy13, end13;
   logic [7:0]  hi8, lo8;
   logic        busy8, end8;

   logic [63:0] res32;
   logic [25:0] res13;
   logic [15:0] res8;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   booth_mult_param #(.WIDTH(32)) u32 (
      .clk(clk), .reset(reset), .mult_ctrl(mult_ctrl), .is_signed(is_signed),
      .a(a[31:0]), .b(b[31:0]), .hi(hi32), .lo(lo32), .busy(busy32), .mult_end(end32));
   booth_mult_param #(.WIDTH(13)) u13 (
      .clk(clk), .reset(reset), .mult_ctrl(mult_ctrl), .is_signed(is_signed),
      .a(a[12:0]), .b(b[12:0]), .hi(hi13), .lo(lo13), .busy(busy13), .mult_end(end13));
   booth_mult_param #(.WIDTH(8)) u8 (
      .clk(clk), .reset(reset), .mult_ctrl(mult_ctrl), .is_signed(is_signed),
      .a(a[7:0]), .b(b[7:0]), .hi(hi8), .lo(lo8), .busy(busy8), .mult_end(end8));

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Exact product of the low w bits of x and y, reduced modulo 2^(2w)
   function automatic logic [127:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input bit sg, input int w);
      logic [127:0] xe, ye, p, mask;
      for (int i = 0; i < 128; i++) begin
         xe[i] = (i < w) ? x[i] : (sg & x[w-1]);
         ye[i] = (i < w) ? y[i] : (sg & y[w-1]);
      end
      p    = xe * ye;
      mask = (128'(1) << (2 * w)) - 128'(1);
      return p & mask;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start one operation on all instances and watch 40 cycles of completions
   task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input bit sg);
      int lat32 = -1, lat13 = -1, lat8 = -1;
      int n32 = 0, n13 = 0, n8 = 0;
      int bad_busy = 0;
      int e32, e13, e8;
      e32 = sg ? 32 : 33;
      e13 = sg ? 13 : 14;
      e8  = sg ? 8 : 9;
      a = av; b = bv; is_signed = sg; mult_ctrl = 1'b1;
      tick();
      mult_ctrl = 1'b0;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; is_signed = 1'($urandom);
      for (int c = 0; c <= 40; c++) begin
         if (c > 0) tick();
         if (end32) begin n32++; if (lat32 < 0) begin lat32 = c; res32 = {hi32, lo32}; end end
         if (end13) begin n13++; if (lat13 < 0) begin lat13 = c; res13 = {hi13, lo13}; end end
         if (end8)  begin n8++;  if (lat8 < 0)  begin lat8 = c;  res8  = {hi8, lo8};    end end
         if (busy32 !== (c < e32)) bad_busy++;
         if (busy13 !== (c < e13)) bad_busy++;
         if (busy8  !== (c < e8))  bad_busy++;
      end
      check("lat32", 128'(lat32), 128'(e32));
      check("lat13", 128'(lat13), 128'(e13));
      check("lat8",  128'(lat8),  128'(e8));
      check("pulses32", 128'(n32), 128'(1));
      check("pulses13", 128'(n13), 128'(1));
      check("pulses8",  128'(n8),  128'(1));
      check("busy_profile", 128'(bad_busy), 128'(0));
      check("prod32", 128'(res32), model(av, bv, sg, 32));
      check("prod13", 128'(res13), model(av, bv, sg, 13));
      check("prod8",  128'(res8),  model(av, bv, sg, 8));
   endtask

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'(1) << $urandom_range(0, 63);
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      int lat;
      int bad;
      reset = 1'b1; mult_ctrl = 1'b0; is_signed = 1'b0; a = '0; b = '0;
      tick(); tick();
      reset = 1'b0;
      check("rst_hi", 128'(hi32), 128'(0));
      check("rst_lo", 128'(lo32), 128'(0));
      check("rst_busy", 128'(busy32), 128'(0));
      check("rst_end", 128'(end32), 128'(0));

      // Directed known products
      run_op(64'd7, 64'hFFFF_FFFD, 1'b1);
      check("t1_prod", 128'(res32), 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFEB);
      run_op(64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
      check("t2u_prod", 128'(res32), 128'hFFFF_FFFE_0000_0001);
      run_op(64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1);
      check("t2s_prod", 128'(res32), 128'h0000_0000_0000_0001);
      run_op(64'h8000_0000, 64'h8000_0000, 1'b1);
      check("t3_prod32", 128'(res32), 128'h4000_0000_0000_0000);
      run_op(64'h80, 64'h80, 1'b1);
      check("t3_prod8s", 128'(res8), 128'h4000);
      run_op(64'hFF, 64'hFF, 1'b0);
      check("t3_prod8u", 128'(res8), 128'hFE01);

      // Start while busy is ignored; back-to-back start in the mult_end cycle
      a = 64'd5; b = 64'd6; is_signed = 1'b1; mult_ctrl = 1'b1;
      tick();
      mult_ctrl = 1'b0;
      repeat (9) tick();
      a = 64'd9; mult_ctrl = 1'b1;
      tick();
      mult_ctrl = 1'b0; a = '0;
      lat = -1;
      for (int c = 11; c <= 40; c++) begin
         tick();
         if (end32) begin lat = c; break; end
      end
      check("ign_lat", 128'(lat), 128'(32));
      check("ign_hi", 128'(hi32), 128'(0));
      check("ign_lo", 128'(lo32), 128'(30));
      a = 64'd9; b = 64'd9; is_signed = 1'b1; mult_ctrl = 1'b1;
      tick();
      mult_ctrl = 1'b0;
      lat = -1; bad = 0;
      for (int c = 0; c <= 40; c++) begin
         if (c > 0) tick();
         if (end32) begin lat = c; break; end
         if ({hi32, lo32} !== 64'd30) bad++;
      end
      check("b2b_lat", 128'(lat), 128'(32));
      check("b2b_hold", 128'(bad), 128'(0));
      check("b2b_hi", 128'(hi32), 128'(0));
      check("b2b_lo", 128'(lo32), 128'(81));
      repeat (40) tick();

      // Reset mid-operation aborts with no completion
      a = 64'd123; b = 64'd456; is_signed = 1'b0; mult_ctrl = 1'b1;
      tick();
      mult_ctrl = 1'b0;
      repeat (14) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", 128'({busy32, busy13, busy8}), 128'(0));
      check("abort_hilo", 128'({hi32, lo32, hi13, lo13, hi8, lo8}), 128'(0));
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (end32 | end13 | end8 | busy32) bad++;
      end
      check("abort_quiet", 128'(bad), 128'(0));

      // Reset wins over a simultaneous start
      reset = 1'b1; mult_ctrl = 1'b1; a = 64'd7; b = 64'd7;
      tick();
      reset = 1'b0; mult_ctrl = 1'b0;
      check("rst_start_busy", 128'({busy32, busy13, busy8}), 128'(0));
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (end32 | end13 | end8 | busy32 | busy13 | busy8) bad++;
      end
      check("rst_start_quiet", 128'(bad), 128'(0));

      // Randomised regression across all widths and both modes
      repeat (1000) run_op(pick(), pick(), 1'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
